// File: rtl/modulo_cursor_matriz_pkg.sv
// modulo_cursor_matriz_pkg: shared constants and types for the cursor stage
// and the 1:4 matrix-quadrant selector that consumes its position.
package modulo_cursor_matriz_pkg;

  localparam int unsigned MATRIX_COLS  = 5;
  localparam int unsigned MATRIX_LINES = 7;
  localparam int unsigned COORD_W      = 3;

  typedef logic [COORD_W-1:0] coord_t;

  // Bit positions of the four buttons inside the internal 4-bit vectors.
  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } state_e;

  // One step along an axis. inc and dec together cancel out.
  // At an edge the coordinate either wraps to the opposite edge or holds.
  function automatic coord_t step_coord(
    input coord_t cur,
    input logic   inc,
    input logic   dec,
    input coord_t last,
    input logic   wrap
  );
    coord_t nxt;
    nxt = cur;
    if (inc && !dec) begin
      if (cur >= last) begin
        nxt = wrap ? coord_t'(0) : cur;
      end else begin
        nxt = cur + 1'b1;
      end
    end else if (dec && !inc) begin
      if (cur == coord_t'(0)) begin
        nxt = wrap ? last : cur;
      end else begin
        nxt = cur - 1'b1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/modulo_cursor_matriz_botao_sync_borda.sv
// botao_sync_borda: 2-FF synchroniser for one active-low raw button plus a
// registered one-cycle press strobe on the synchronised 1->0 transition.
// A button already held when reset is released does not count as a press;
// it must be released and pressed again.
module botao_sync_borda (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level_n,
  output logic press
);

  logic [1:0] sync_q;
  logic [1:0] fill_q;
  logic       prev_q;
  logic       press_q;

  // Synchroniser, edge history and strobe register.
  // fill_q marks when sync_q[1] carries a real sample rather than the reset
  // value, so a level that is low straight out of reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n};
      fill_q  <= {fill_q[0], 1'b1};
      prev_q  <= fill_q[1] & sync_q[1];
      press_q <= prev_q & ~sync_q[1];
    end
  end

  assign level_n = sync_q[1];
  assign press   = press_q;

endmodule

// File: rtl/modulo_cursor_matriz.sv
// modulo_cursor_matriz: turns four raw push-buttons into a registered cursor
// position (mdc column, mdl line) on the 5x7 LED matrix, with a one-cycle
// moved strobe whenever the position changes.
// Optional feature: define AUTO_REPEAT_EN for hold-to-auto-repeat stepping.
module modulo_cursor_matriz
  import modulo_cursor_matriz_pkg::*;
#(
  parameter int unsigned N_COLS        = MATRIX_COLS,
  parameter int unsigned N_LINES       = MATRIX_LINES,
  parameter bit          WRAP          = 1'b1,
  parameter int unsigned HOLD_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               btn_up_n,
  input  logic               btn_down_n,
  input  logic               btn_left_n,
  input  logic               btn_right_n,
  output logic [COORD_W-1:0] mdc,
  output logic [COORD_W-1:0] mdl,
  output logic               moved
);

  localparam coord_t LAST_COL  = coord_t'(N_COLS - 1);
  localparam coord_t LAST_LINE = coord_t'(N_LINES - 1);

  logic [3:0] btn_n;
  logic [3:0] level_n;
  logic [3:0] press;
  logic [3:0] held;
  logic [3:0] step_req;
  logic       any_held;
  logic       any_press;
  state_e     state_q;
  state_e     state_d;
  coord_t     mdc_d;
  coord_t     mdl_d;

  // Gather the raw buttons into one vector indexed by direction.
  always_comb begin
    btn_n            = '1;
    btn_n[DIR_UP]    = btn_up_n;
    btn_n[DIR_DOWN]  = btn_down_n;
    btn_n[DIR_LEFT]  = btn_left_n;
    btn_n[DIR_RIGHT] = btn_right_n;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    botao_sync_borda u_sync (
      .clk     (clk),
      .rst     (rst),
      .btn_n   (btn_n[gi]),
      .level_n (level_n[gi]),
      .press   (press[gi])
    );
  end

  assign held      = ~level_n;
  assign any_held  = |held;
  assign any_press = |press;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic              one_held;
  logic              hold_done;
  logic              rep_done;
  logic              hold_run;
  logic              rep_run;

  assign one_held  = any_held && ((held & (held - 4'd1)) == 4'd0);
  assign hold_done = (hold_cnt == HOLD_LAST);
  assign rep_done  = (rep_cnt == REP_LAST);
  assign hold_run  = (state_q == HELD) && (state_d == HELD) && !any_press;
  assign rep_run   = (state_q == REPEAT) && (state_d == REPEAT);

  // Hold timer saturates at its terminal count; repeat timer wraps and
  // triggers one step per wrap. Both restart whenever their state is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      if (!hold_run) begin
        hold_cnt <= '0;
      end else if (!hold_done) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (!rep_run || rep_done) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`else
  // Repeat timing has no effect without auto-repeat.
  logic unused_timing;
  assign unused_timing = ^{HOLD_CYCLES, REPEAT_CYCLES};
`endif

  // Press-tracking FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and step requests. Fresh strobes apply in every state;
  // disabling drops them and parks the FSM so a held button cannot resume.
  always_comb begin
    state_d  = state_q;
    step_req = '0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      step_req = press;
      case (state_q)
        IDLE: begin
          if (any_press) begin
            state_d = HELD;
          end
        end
        HELD: begin
          if (!any_held) begin
            state_d = IDLE;
          end
`ifdef AUTO_REPEAT_EN
          else if (one_held && hold_done && !any_press) begin
            state_d = REPEAT;
          end
`endif
        end
`ifdef AUTO_REPEAT_EN
        REPEAT: begin
          if (!any_held) begin
            state_d = IDLE;
          end else if (any_press || !one_held) begin
            state_d = HELD;
          end else if (rep_done) begin
            step_req = held;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Candidate position from this cycle's step requests.
  always_comb begin
    mdc_d = step_coord(mdc, step_req[DIR_RIGHT], step_req[DIR_LEFT], LAST_COL, WRAP);
    mdl_d = step_coord(mdl, step_req[DIR_DOWN], step_req[DIR_UP], LAST_LINE, WRAP);
  end

  // Position registers; moved only flags a real change of value.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdc   <= '0;
      mdl   <= '0;
      moved <= 1'b0;
    end else begin
      mdc   <= mdc_d;
      mdl   <= mdl_d;
      moved <= (mdc_d != mdc) || (mdl_d != mdl);
    end
  end

endmodule

// File: tb/tb_modulo_cursor_matriz.sv
// tb_modulo_cursor_matriz: directed bench driving a wrapping and a saturating
// cursor instance with the same button stimulus.
module tb_modulo_cursor_matriz;

  localparam logic [3:0] B_UP    = 4'b0001;
  localparam logic [3:0] B_DOWN  = 4'b0010;
  localparam logic [3:0] B_LEFT  = 4'b0100;
  localparam logic [3:0] B_RIGHT = 4'b1000;

`ifdef AUTO_REPEAT_EN
  localparam logic [2:0] EXP_MID   = 3'd2;
  localparam logic [2:0] EXP_FINAL = 3'd5;
  localparam int         EXP_MOVES = 5;
`else
  localparam logic [2:0] EXP_MID   = 3'd1;
  localparam logic [2:0] EXP_FINAL = 3'd1;
  localparam int         EXP_MOVES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       btn_up_n;
  logic       btn_down_n;
  logic       btn_left_n;
  logic       btn_right_n;
  logic [2:0] mdc_w, mdl_w, mdc_s, mdl_s;
  logic       moved_w, moved_s;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  modulo_cursor_matriz #(.WRAP(1'b1), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut_wrap (
    .clk(clk), .rst(rst), .en(en),
    .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
    .btn_left_n(btn_left_n), .btn_right_n(btn_right_n),
    .mdc(mdc_w), .mdl(mdl_w), .moved(moved_w)
  );

  modulo_cursor_matriz #(.WRAP(1'b0), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut_sat (
    .clk(clk), .rst(rst), .en(en),
    .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
    .btn_left_n(btn_left_n), .btn_right_n(btn_right_n),
    .mdc(mdc_s), .mdl(mdl_s), .moved(moved_s)
  );

  task automatic set_btns(input logic [3:0] low);
    btn_up_n    = ~low[0];
    btn_down_n  = ~low[1];
    btn_left_n  = ~low[2];
    btn_right_n = ~low[3];
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    repeat (4) cycle();
  endtask

  // Buttons low for two sampling edges; returns just after the update edge.
  task automatic press2(input logic [3:0] mask);
    set_btns(mask);
    cycle();
    cycle();
    set_btns(4'b0000);
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    checks++;
    if ({mdc_w, mdl_w, moved_w} !== 7'd0) begin
      errors++;
      $display("FAIL reset_wrap: got mdc=%0d mdl=%0d moved=%0b, expected 0 0 0", mdc_w, mdl_w, moved_w);
    end
    checks++;
    if ({mdc_s, mdl_s, moved_s} !== 7'd0) begin
      errors++;
      $display("FAIL reset_sat: got mdc=%0d mdl=%0d moved=%0b, expected 0 0 0", mdc_s, mdl_s, moved_s);
    end
    rst = 1'b0;
    repeat (4) cycle();
    checks++;
    if ({mdc_w, mdl_w, moved_w, mdc_s, mdl_s, moved_s} !== 14'd0) begin
      errors++;
      $display("FAIL reset_release: got %0d %0d %0b / %0d %0d %0b, expected all 0",
               mdc_w, mdl_w, moved_w, mdc_s, mdl_s, moved_s);
    end
  endtask

  task automatic test_single_step();
    set_btns(B_RIGHT);
    cycle();
    cycle();
    set_btns(4'b0000);
    cycle();
    checks++;
    if ({mdc_w, mdl_w, moved_w} !== {3'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL latency_early: got mdc=%0d mdl=%0d moved=%0b, expected 0 0 0", mdc_w, mdl_w, moved_w);
    end
    cycle();
    checks++;
    if ({mdc_w, mdl_w, moved_w} !== {3'd1, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL step_right_wrap: got mdc=%0d mdl=%0d moved=%0b, expected 1 0 1", mdc_w, mdl_w, moved_w);
    end
    checks++;
    if ({mdc_s, mdl_s, moved_s} !== {3'd1, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL step_right_sat: got mdc=%0d mdl=%0d moved=%0b, expected 1 0 1", mdc_s, mdl_s, moved_s);
    end
    cycle();
    checks++;
    if ({mdc_w, mdl_w, moved_w, moved_s} !== {3'd1, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL moved_one_cycle: got mdc=%0d mdl=%0d moved=%0b/%0b, expected 1 0 0/0",
               mdc_w, mdl_w, moved_w, moved_s);
    end
    repeat (2) cycle();
  endtask

  task automatic test_boundaries();
    logic [2:0] exp_w [0:3];
    logic [2:0] exp_s [0:3];
    logic       mv_s  [0:3];
    exp_w = '{3'd2, 3'd3, 3'd4, 3'd0};
    exp_s = '{3'd2, 3'd3, 3'd4, 3'd4};
    mv_s  = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      press2(B_RIGHT);
      checks++;
      if ({mdc_w, moved_w} !== {exp_w[i], 1'b1}) begin
        errors++;
        $display("FAIL right_wrap[%0d]: got mdc=%0d moved=%0b, expected %0d 1", i, mdc_w, moved_w, exp_w[i]);
      end
      checks++;
      if ({mdc_s, moved_s} !== {exp_s[i], mv_s[i]}) begin
        errors++;
        $display("FAIL right_sat[%0d]: got mdc=%0d moved=%0b, expected %0d %0b", i, mdc_s, moved_s, exp_s[i], mv_s[i]);
      end
      repeat (2) cycle();
    end
    press2(B_UP);
    checks++;
    if ({mdc_w, mdl_w, moved_w} !== {3'd0, 3'd6, 1'b1}) begin
      errors++;
      $display("FAIL up_wrap: got mdc=%0d mdl=%0d moved=%0b, expected 0 6 1", mdc_w, mdl_w, moved_w);
    end
    checks++;
    if ({mdc_s, mdl_s, moved_s} !== {3'd4, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL up_sat: got mdc=%0d mdl=%0d moved=%0b, expected 4 0 0", mdc_s, mdl_s, moved_s);
    end
    repeat (2) cycle();
  endtask

  task automatic test_simultaneous();
    int mv;
    do_reset();
    press2(B_DOWN | B_RIGHT);
    checks++;
    if ({mdc_w, mdl_w, moved_w, mdc_s, mdl_s, moved_s} !== {3'd1, 3'd1, 1'b1, 3'd1, 3'd1, 1'b1}) begin
      errors++;
      $display("FAIL diag_first: got %0d %0d %0b / %0d %0d %0b, expected 1 1 1 / 1 1 1",
               mdc_w, mdl_w, moved_w, mdc_s, mdl_s, moved_s);
    end
    cycle();
    checks++;
    if ({moved_w, moved_s} !== 2'b00) begin
      errors++;
      $display("FAIL diag_single_pulse: got moved=%0b/%0b, expected 0/0", moved_w, moved_s);
    end
    cycle();
    press2(B_DOWN | B_RIGHT);
    checks++;
    if ({mdc_w, mdl_w, moved_w} !== {3'd2, 3'd2, 1'b1}) begin
      errors++;
      $display("FAIL diag_1_1: got mdc=%0d mdl=%0d moved=%0b, expected 2 2 1", mdc_w, mdl_w, moved_w);
    end
    repeat (2) cycle();
    press2(B_DOWN);
    repeat (2) cycle();
    press2(B_UP | B_DOWN);
    checks++;
    if ({mdc_w, mdl_w, moved_w, mdc_s, mdl_s, moved_s} !== {3'd2, 3'd3, 1'b0, 3'd2, 3'd3, 1'b0}) begin
      errors++;
      $display("FAIL up_down_cancel: got %0d %0d %0b / %0d %0d %0b, expected 2 3 0 / 2 3 0",
               mdc_w, mdl_w, moved_w, mdc_s, mdl_s, moved_s);
    end
    repeat (2) cycle();
    press2(B_LEFT | B_RIGHT);
    checks++;
    if ({mdc_w, mdl_w, moved_w} !== {3'd2, 3'd3, 1'b0}) begin
      errors++;
      $display("FAIL left_right_cancel: got mdc=%0d mdl=%0d moved=%0b, expected 2 3 0", mdc_w, mdl_w, moved_w);
    end
    mv = 0;
    repeat (4) begin
      cycle();
      mv += int'(moved_w) + int'(moved_s);
    end
    checks++;
    if (mv !== 0) begin
      errors++;
      $display("FAIL cancel_no_moved: got %0d pulses, expected 0", mv);
    end
  endtask

  task automatic test_enable();
    int mv;
    en = 1'b0;
    press2(B_LEFT);
    checks++;
    if ({mdc_w, mdl_w, moved_w, mdc_s, moved_s} !== {3'd2, 3'd3, 1'b0, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL en_low_press: got %0d %0d %0b / %0d %0b, expected 2 3 0 / 2 0",
               mdc_w, mdl_w, moved_w, mdc_s, moved_s);
    end
    repeat (2) cycle();
    set_btns(B_LEFT);
    repeat (5) cycle();
    en = 1'b1;
    mv = 0;
    repeat (8) begin
      cycle();
      mv += int'(moved_w) + int'(moved_s);
    end
    checks++;
    if (mv !== 0 || mdc_w !== 3'd2) begin
      errors++;
      $display("FAIL en_rise_held: got mdc=%0d pulses=%0d, expected 2 0", mdc_w, mv);
    end
    set_btns(4'b0000);
    repeat (3) cycle();
    press2(B_LEFT);
    checks++;
    if ({mdc_w, mdl_w, moved_w, mdc_s, mdl_s, moved_s} !== {3'd1, 3'd3, 1'b1, 3'd1, 3'd3, 1'b1}) begin
      errors++;
      $display("FAIL en_repress: got %0d %0d %0b / %0d %0d %0b, expected 1 3 1 / 1 3 1",
               mdc_w, mdl_w, moved_w, mdc_s, mdl_s, moved_s);
    end
    repeat (2) cycle();
  endtask

  task automatic test_hold();
    int mv;
    do_reset();
    set_btns(B_DOWN);
    mv = 0;
    for (int i = 0; i < 35; i++) begin
      cycle();
      mv += int'(moved_w);
      if (i == 3) begin
        checks++;
        if (mdl_w !== 3'd1) begin
          errors++;
          $display("FAIL hold_first_step: got mdl=%0d, expected 1", mdl_w);
        end
      end
      if (i == 14) begin
        checks++;
        if (mdl_w !== 3'd1) begin
          errors++;
          $display("FAIL hold_before_repeat: got mdl=%0d, expected 1", mdl_w);
        end
      end
      if (i == 15) begin
        checks++;
        if (mdl_w !== EXP_MID) begin
          errors++;
          $display("FAIL hold_repeat_start: got mdl=%0d, expected %0d", mdl_w, EXP_MID);
        end
      end
      if (i == 27) begin
        set_btns(4'b0000);
      end
    end
    checks++;
    if ({mdl_w, mdl_s} !== {EXP_FINAL, EXP_FINAL} || mv !== EXP_MOVES) begin
      errors++;
      $display("FAIL hold_final: got mdl=%0d/%0d pulses=%0d, expected %0d/%0d %0d",
               mdl_w, mdl_s, mv, EXP_FINAL, EXP_FINAL, EXP_MOVES);
    end

    do_reset();
    set_btns(B_DOWN);
    repeat (17) cycle();
    checks++;
    if (mdl_w !== EXP_MID) begin
      errors++;
      $display("FAIL hold_before_rst: got mdl=%0d, expected %0d", mdl_w, EXP_MID);
    end
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    mv = 0;
    repeat (30) begin
      cycle();
      mv += int'(moved_w) + int'(moved_s);
    end
    checks++;
    if ({mdc_w, mdl_w, mdc_s, mdl_s} !== 12'd0 || mv !== 0) begin
      errors++;
      $display("FAIL rst_mid_hold: got %0d %0d / %0d %0d pulses=%0d, expected 0 0 / 0 0 0",
               mdc_w, mdl_w, mdc_s, mdl_s, mv);
    end
    set_btns(4'b0000);
    repeat (4) cycle();
    press2(B_DOWN);
    checks++;
    if ({mdc_w, mdl_w, moved_w} !== {3'd0, 3'd1, 1'b1}) begin
      errors++;
      $display("FAIL rst_repress: got mdc=%0d mdl=%0d moved=%0b, expected 0 1 1", mdc_w, mdl_w, moved_w);
    end
    repeat (2) cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    set_btns(4'b0000);
    test_reset();
    test_single_step();
    test_boundaries();
    test_simultaneous();
    test_enable();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/modulo_cursor_matriz.md
Name: modulo_cursor_matriz

Overview:
- Upstream stage of the 1:4 matrix-quadrant selector.
- Converts four raw push-button inputs into a registered cursor position: column mdc (0..4) and line mdl (0..6) on the 5x7 LED matrix.
- The selector consumes that position combinationally to drive its demux select.
- Provides synchronisation, press detection, boundary handling and a move strobe.

Parameters:
- N_COLS, 5, number of matrix columns; mdc range 0..N_COLS-1
- N_LINES, 7, number of matrix lines; mdl range 0..N_LINES-1
- WRAP, 1, 1 = wrap-around at edges, 0 = saturate at edges
- HOLD_CYCLES, 25000000, hold time before auto-repeat starts (AUTO_REPEAT_EN only)
- REPEAT_CYCLES, 5000000, auto-repeat step period (AUTO_REPEAT_EN only)

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  1 = accept presses; 0 = presses discarded, not queued
- btn_up_n  input  1  raw button, active-low, asynchronous; decrements mdl
- btn_down_n  input  1  raw button, active-low; increments mdl
- btn_left_n  input  1  raw button, active-low; decrements mdc
- btn_right_n  input  1  raw button, active-low; increments mdc
- mdc  output  3  cursor column, registered
- mdl  output  3  cursor line, registered
- moved  output  1  one-cycle pulse in the cycle after mdc or mdl changes

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high.
- Reset values:
  - mdc = 0, mdl = 0, moved = 0.
  - Synchroniser flops = 1 (released).
  - FSM = IDLE; hold and repeat counters = 0.
  - rst during a held button: after release of rst, the still-low button generates no press. A new falling edge is required.
- Input path: each button passes through a 2-FF synchroniser. A press is a 1->0 transition of the synchronised level, giving a one-cycle press strobe.
- Latency:
  - A button first sampled low at edge k updates mdc/mdl at edge k+3 (2 synchroniser stages + 1 update).
  - moved is high during the cycle after edge k+3.
- Step rules:
  - up: mdl-1; down: mdl+1; left: mdc-1; right: mdc+1.
  - Arithmetic is 3-bit. Results never leave the legal ranges.
- Boundaries:
  - WRAP=1: right at N_COLS-1 -> 0; left at 0 -> N_COLS-1; down at N_LINES-1 -> 0; up at 0 -> N_LINES-1.
  - WRAP=0: position holds at the edge and no moved pulse is produced.
- Simultaneous strobes:
  - up+down in the same cycle: mdl unchanged.
  - left+right in the same cycle: mdc unchanged.
  - Orthogonal pairs (e.g. up+right) both apply in the same cycle, giving one moved pulse.
- en=0: strobes dropped and FSM forced to IDLE. en rising while a button is held: no move until a fresh press.
- FSM states:
  - IDLE: all synchronised buttons released. A press strobe applies the step and goes to HELD.
  - HELD: at least one button low; hold counter increments. All released -> IDLE. With AUTO_REPEAT_EN, exactly one button low and the counter reaching HOLD_CYCLES-1 -> REPEAT.
  - REPEAT: repeat counter wraps every REPEAT_CYCLES and re-applies that button's step. Any second button pressed, or the held button released -> HELD (counters cleared) or IDLE.
- New strobes in HELD/REPEAT (a second button pressed) apply immediately, same rules as in IDLE.
- moved is asserted only when the registered value actually changed.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined: HOLD/REPEAT behaviour as above, with counters sized $clog2 of HOLD_CYCLES / REPEAT_CYCLES.
- Undefined: no REPEAT state and no counters. HELD only waits for all buttons released. Exactly one step per press.

Decomposition:
- Shared package:
  - MATRIX_COLS=5, MATRIX_LINES=7, COORD_W=3.
  - Direction encoding typedef (DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT).
  - FSM state typedef (IDLE, HELD, REPEAT).
  - The selector also imports these constants.
- Sub-module botao_sync_borda: 2-FF synchroniser plus falling-edge strobe, reset to released. Instantiated 4 times.

Test Plan:
- Reset, then right_n low 2 cycles then high -> mdc 0->1 at 3rd edge after the low sample; moved one cycle; mdl stays 0.
- WRAP=1: 5 right presses from mdc=0 -> mdc sequence 1,2,3,4,0; then up once from mdl=0 -> mdl=6.
- WRAP=0: at mdc=4 press right -> mdc stays 4, moved stays 0; up at mdl=0 -> stays 0.
- Same-cycle strobes:
  - up+down together at mdl=3 -> mdl=3, no moved.
  - down+right together at (1,1) -> (2,2) with a single moved pulse.
- en=0, press left -> no change; raise en while left held -> no change; release and re-press -> mdc-1.
- AUTO_REPEAT_EN, HOLD_CYCLES=8, REPEAT_CYCLES=4: hold down for 30 cycles from mdl=0 -> step at press, then every 4 cycles after hold -> mdl 1,2,3,4,5. rst asserted mid-hold -> (0,0), no further steps until re-press.
